// File: rtl/ppc_decode_pkg.sv
// Shared decode definitions for the load/store multiple-word expansion path.
package ppc_decode_pkg;

    // Primary opcodes of the multiple-word load/store instructions.
    localparam logic [5:0] OP_LMW  = 6'd46;
    localparam logic [5:0] OP_STMW = 6'd47;

    // How a micro-op uses its data register; shared with downstream consumers.
    typedef enum logic [1:0] {
        REG_IMM        = 2'd0,
        REG_READ       = 2'd1,
        REG_WRITE      = 2'd2,
        REG_READ_WRITE = 2'd3
    } reg_use_t;

    // Sequencer FSM states.
    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } seq_state_t;

endpackage

// File: rtl/multiple_word_sequencer.sv
// Expands lmw/stmw into one single-word micro-op per register, RT through r31,
// holding decode with stall_o until the final micro-op is accepted.
module multiple_word_sequencer
    import ppc_decode_pkg::*;
#(
    parameter int regWidth = 5,
    parameter int immWidth = 16,
    parameter int offWidth = 18
) (
    input  logic                clock_i,
    input  logic                resetn_i,
    input  logic                enable_i,
    input  logic [5:0]          opcode_i,
    input  logic [regWidth-1:0] rt_i,
    input  logic [regWidth-1:0] ra_i,
    input  logic [immWidth-1:0] imm_i,
    output logic                stall_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                isStore_o,
    output logic [regWidth-1:0] reg_o,
    output logic [regWidth-1:0] base_o,
    output logic                baseZero_o,
    output logic [offWidth-1:0] offset_o,
    output logic                last_o,
    output logic                invalidForm_o
);

    localparam logic [regWidth-1:0] LAST_REG = '1;

    seq_state_t          state_q;
    seq_state_t          state_d;

    logic [regWidth-1:0] cur_reg_q;
    logic [regWidth-1:0] base_q;
    logic [offWidth-1:0] offset_q;
    logic                is_store_q;
    logic                base_zero_q;
    logic                invalid_q;

    logic                issuing;
    logic                at_last;
    logic                handshake;
    logic                handshake_last;
    logic                is_multiple_op;
    logic                capture;
    logic [offWidth-1:0] imm_sext;

    assign issuing        = (state_q == ISSUE);
    assign at_last        = (cur_reg_q == LAST_REG);
    assign handshake      = issuing & ready_i;
    assign handshake_last = handshake & at_last;
    assign is_multiple_op = (opcode_i == OP_LMW) || (opcode_i == OP_STMW);
    // A new instruction is taken when idle, or on the very edge that retires
    // the previous sequence's final micro-op, so back-to-back runs have no bubble.
    assign capture        = enable_i & is_multiple_op & (~issuing | handshake_last);
    assign imm_sext       = {{(offWidth-immWidth){imm_i[immWidth-1]}}, imm_i};

    // State register.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: capture wins over the return to IDLE.
    // NOTE: the default assignment at the top keeps this block free of latches.
    always_comb begin
        state_d = state_q;
        if (capture) begin
            state_d = ISSUE;
        end else if (handshake_last) begin
            state_d = IDLE;
        end
    end

    // Sequence datapath: operands latched at capture, register index and
    // running offset advanced by one word per accepted micro-op.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            cur_reg_q   <= '0;
            base_q      <= '0;
            offset_q    <= '0;
            is_store_q  <= 1'b0;
            base_zero_q <= 1'b0;
            invalid_q   <= 1'b0;
        end else if (capture) begin
            cur_reg_q   <= rt_i;
            base_q      <= ra_i;
            offset_q    <= imm_sext;
            is_store_q  <= (opcode_i == OP_STMW);
            base_zero_q <= (ra_i == '0);
            // lmw overwriting its own base register is an invalid form.
            invalid_q   <= (opcode_i == OP_LMW) && (ra_i >= rt_i);
        end else if (handshake && !at_last) begin
            cur_reg_q   <= cur_reg_q + regWidth'(1);
            offset_q    <= offset_q + offWidth'(4);
        end
    end

    // Outputs: micro-op fields are only presented while issuing, zero otherwise.
    always_comb begin
        valid_o       = issuing;
        isStore_o     = issuing & is_store_q;
        reg_o         = issuing ? cur_reg_q : '0;
        base_o        = issuing ? base_q    : '0;
        baseZero_o    = issuing & base_zero_q;
        offset_o      = issuing ? offset_q  : '0;
        last_o        = issuing & at_last;
        invalidForm_o = issuing & invalid_q;
        stall_o       = issuing & ~handshake_last;
    end

endmodule

// File: doc/multiple_word_sequencer.md
# multiple_word_sequencer

Expands Load Multiple Word (opcode 46) and Store Multiple Word (opcode 47) into one single-word micro-op per register, RT through r31. Sits between the D-format decode stage and the load/store issue path. Holds decode with `stall_o` until the last micro-op has been accepted downstream. All other opcodes are ignored and are routed by the normal decode path.

## Interface
Parameters:
- `regWidth`, 5: register address width.
- `immWidth`, 16: D-field width.
- `offWidth`, 18: signed micro-op offset width, immWidth+2.

Ports:
- `clock_i`, in, 1: clock, rising edge.
- `resetn_i`, in, 1: reset, asynchronous, active-low.
- `enable_i`, in, 1: decoded D-format instruction valid.
- `opcode_i`, in, 6: primary opcode of that instruction.
- `rt_i`, in, regWidth: RT/RS field.
- `ra_i`, in, regWidth: RA field.
- `imm_i`, in, immWidth: D field, signed.
- `stall_o`, out, 1: decode must hold its outputs stable.
- `valid_o`, out, 1: micro-op valid.
- `ready_i`, in, 1: downstream accepts the micro-op.
- `isStore_o`, out, 1: 1 = stw micro-op, 0 = lwz micro-op.
- `reg_o`, out, regWidth: data register, RT+k.
- `base_o`, out, regWidth: RA.
- `baseZero_o`, out, 1: RA==0, so the base is literal zero.
- `offset_o`, out, offWidth: sext(imm)+4k.
- `last_o`, out, 1: final micro-op of the sequence.
- `invalidForm_o`, out, 1: lmw with RA in the range RT..31.

## Operation
- FSM has two states.
  - `IDLE`: `valid_o`=0.
  - `ISSUE`: `valid_o`=1.
- Capture happens when `enable_i`=1, `opcode_i` is 46 or 47, and either (a) state is IDLE, or (b) state is ISSUE and this cycle's handshake (`valid_o`&`ready_i`) carries `last_o`=1.
  - On capture, register `rt_i`, `ra_i`, sext(`imm_i`) and isStore (opcode==47).
  - Set k=0 and go to ISSUE.
- In ISSUE, each handshake increments k:
  - `reg_o` = RT+k.
  - `offset_o` = sext(imm) + (k<<2), in offWidth-bit two's-complement arithmetic. This never overflows: the range is -32768..32767+124.
- `last_o` = (RT+k == 31), computed in regWidth bits with no wrap. RT=31 yields exactly one micro-op. The total count is 32-RT.
- A handshake with `last_o` and no new capture returns the FSM to IDLE.
- `stall_o` is combinational: `stall_o` = ISSUE & !(`valid_o` & `ready_i` & `last_o`).
  - It drops in the cycle the last micro-op is accepted, so decode advances and a following lmw/stmw can be captured at that same edge with zero bubble.
- `enable_i` with any other opcode: no capture, no state change, `stall_o` unaffected.
- `enable_i` arriving while `stall_o`=1 is not captured. Decode holds it, and it is re-presented.
- `invalidForm_o` = !isStore & (RA >= RT), registered at capture and held for the whole sequence.
  - The sequence still issues in full; the exception is raised downstream.
  - stmw never flags.
- `baseZero_o` = (RA==0), registered at capture.

## Timing
- Capture at edge N. First micro-op (k=0) is visible from N+1.
- With `ready_i` held at 1, one micro-op issues per cycle: 32-RT cycles, last accepted at edge N+32-RT.
- With `ready_i`=0, all micro-op outputs hold stable and `valid_o` stays 1. No micro-op is dropped or repeated.
- Reset values, applied asynchronously on `resetn_i`=0 (any time, including mid-sequence):
  - FSM = IDLE.
  - `valid_o`, `isStore_o`, `last_o`, `invalidForm_o`, `baseZero_o` = 0.
  - `reg_o`, `base_o` = 0; `offset_o` = 0; `stall_o` = 0.
  - The in-flight sequence is abandoned, not resumed.
- After reset deasserts, the first capture is possible at the first rising edge.

## Structure
- Shared package `ppc_decode_pkg` holds:
  - Opcode constants: `OP_LMW`=46, `OP_STMW`=47.
  - Register-use encodings (regImm=0, regRead=1, regWrite=2, regReadWrite=3), so downstream micro-op consumers can reuse them.
  - The FSM state typedef.
- No sub-modules. A single FSM plus a k counter and an offset adder.
  - The offset is kept as a running accumulator (+4 per handshake) rather than a multiplier.

## Test plan
- lmw RT=29, RA=1, imm=8, `ready_i`=1 → three micro-ops at N+1..N+3:
  - reg 29/30/31, offset 8/12/16, `last_o` on the third only.
  - `isStore_o`=0; `stall_o` high at N+1, N+2, low at N+3.
- stmw RT=31, RA=0, imm=0xFFFC → one micro-op:
  - reg 31, offset -4, `baseZero_o`=1, `isStore_o`=1, `last_o`=1.
  - `stall_o`=0 during that cycle.
- lmw RT=30, imm=0 with `ready_i` toggling 0,1,0,0,1 → micro-ops held stable while not ready; exactly reg 30 then reg 31, offsets 0 then 4.
- Back-to-back cases:
  - stmw RT=30 followed immediately by lmw RT=31 → three micro-ops in three consecutive cycles, with no IDLE cycle between them.
  - opcode 14 with `enable_i` at any point → ignored.
- lmw RT=28, RA=30 → `invalidForm_o`=1 on all four micro-ops.
- stmw RT=28, RA=30 → `invalidForm_o`=0.
- `resetn_i` pulsed low after the second micro-op of lmw RT=24 → all outputs 0 immediately, FSM in IDLE, and no further micro-ops.
